// File: rtl/mips_imem_pkg.sv
// Shared types and constants for the loadable MIPS instruction memory.
package mips_imem_pkg;

    typedef enum logic {
        LOAD = 1'b0,
        RUN  = 1'b1
    } imem_state_e;

    localparam logic [31:0] IMEM_RESET_VECTOR = 32'hBFC00000;
    localparam logic [31:0] HALT_ADDR         = 32'h0;

    // Reverse byte order of a 32-bit word.
    function automatic logic [31:0] bswap32(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

endpackage

// File: rtl/mips_imem_byte_packer.sv
// Packs a big-endian byte stream into 32-bit words; a last byte flushes a
// partial word with its unfilled lower lanes zeroed.
module mips_imem_byte_packer (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        byte_en,
    input  logic [7:0]  byte_in,
    input  logic        byte_last,
    output logic        word_valid,
    output logic [31:0] word
);

    logic [1:0]  idx_q, idx_d;
    logic [23:0] lanes_q, lanes_d;

    always_comb begin
        idx_d      = idx_q;
        lanes_d    = lanes_q;
        word_valid = 1'b0;
        word       = '0;
        case (idx_q)
            2'd0:    word = {byte_in, 24'h0};
            2'd1:    word = {lanes_q[7:0], byte_in, 16'h0};
            2'd2:    word = {lanes_q[15:0], byte_in, 8'h0};
            default: word = {lanes_q[23:0], byte_in};
        endcase
        if (byte_en) begin
            if (byte_last || (idx_q == 2'd3)) begin
                word_valid = 1'b1;
                idx_d      = '0;
                lanes_d    = '0;
            end else begin
                idx_d   = idx_q + 2'd1;
                lanes_d = {lanes_q[15:0], byte_in};
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            idx_q   <= '0;
            lanes_q <= '0;
        end else begin
            idx_q   <= idx_d;
            lanes_q <= lanes_d;
        end
    end

endmodule

// File: rtl/mips_cpu_instr_memory.sv
// Loadable instruction memory: byte-stream program load, then combinational
// fetch service with sticky halt/error flags. IMEM_BYTESWAP_EN selects
// little-endian bus order on instr_readdata.
module mips_cpu_instr_memory
    import mips_imem_pkg::*;
#(
    parameter int unsigned DEPTH     = 64,
    parameter logic [31:0] BASE_ADDR = IMEM_RESET_VECTOR
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     load_valid,
    input  logic [7:0]               load_byte,
    input  logic                     load_last,
    output logic                     load_ready,
    output logic                     load_done,
    output logic [$clog2(DEPTH):0]   load_count,
    output logic                     cpu_reset,
    input  logic [31:0]              instr_address,
    output logic [31:0]              instr_readdata,
    output logic                     halted,
    output logic                     fetch_error
);

    localparam int unsigned AW   = $clog2(DEPTH);
    localparam int unsigned CW   = AW + 1;
    localparam logic [31:0] SPAN = 32'(4 * DEPTH);

    imem_state_e       state_q, state_d;
    logic [CW-1:0]     load_count_q, load_count_d;
    logic [DEPTH-1:0]  valid_q, valid_d;
    logic              halted_q, halted_d;
    logic              fetch_error_q, fetch_error_d;
    logic [31:0]       mem_q [DEPTH];

    logic              byte_en;
    logic              word_valid;
    logic [31:0]       word;
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_idx;
    logic [31:0]       offset;
    logic [31:0]       rd_word;
    logic              hit;

    assign byte_en = (state_q == LOAD) && load_valid;
    assign wr_ptr  = load_count_q[AW-1:0];

    mips_imem_byte_packer u_packer (
        .clk        (clk),
        .reset_n    (reset_n),
        .byte_en    (byte_en),
        .byte_in    (load_byte),
        .byte_last  (load_last),
        .word_valid (word_valid),
        .word       (word)
    );

    // Fetch decode; offset cannot wrap once the lower bound check passes.
    always_comb begin
        offset  = instr_address - BASE_ADDR;
        rd_idx  = offset[AW+1:2];
        rd_word = mem_q[rd_idx];
        hit     = (state_q == RUN) && (offset[1:0] == 2'b00) &&
                  (instr_address >= BASE_ADDR) && (offset < SPAN) &&
                  valid_q[rd_idx];
        instr_readdata = '0;
        if (hit) begin
`ifdef IMEM_BYTESWAP_EN
            instr_readdata = bswap32(rd_word);
`else
            instr_readdata = rd_word;
`endif
        end
    end

    // Load sequencing and run-mode flag capture.
    always_comb begin
        state_d       = state_q;
        load_count_d  = load_count_q;
        valid_d       = valid_q;
        halted_d      = halted_q;
        fetch_error_d = fetch_error_q;
        if (state_q == LOAD) begin
            if (word_valid) begin
                valid_d[wr_ptr] = 1'b1;
                load_count_d    = load_count_q + CW'(1);
                if (load_last || (load_count_d == CW'(DEPTH))) begin
                    state_d = RUN;
                end
            end
        end else begin
            if (instr_address == HALT_ADDR) begin
                halted_d = 1'b1;
            end else if (!hit) begin
                fetch_error_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= LOAD;
            load_count_q  <= '0;
            valid_q       <= '0;
            halted_q      <= 1'b0;
            fetch_error_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            load_count_q  <= load_count_d;
            valid_q       <= valid_d;
            halted_q      <= halted_d;
            fetch_error_q <= fetch_error_d;
        end
    end

    // Storage array is not reset; the valid bits gate every read.
    always_ff @(posedge clk) begin
        if (word_valid) begin
            mem_q[wr_ptr] <= word;
        end
    end

    assign load_ready  = (state_q == LOAD);
    assign load_done   = (state_q == RUN);
    assign cpu_reset   = (state_q == LOAD);
    assign load_count  = load_count_q;
    assign halted      = halted_q;
    assign fetch_error = fetch_error_q;

endmodule

// File: tb/tb_mips_cpu_instr_memory.sv
// Directed bench for mips_cpu_instr_memory: fetch vector table plus load,
// padding, full, halt/error and mid-load reset sequences.
module tb_mips_cpu_instr_memory;

    localparam int unsigned DEPTH = 64;

    logic        clk;
    logic        reset_n;
    logic        load_valid;
    logic [7:0]  load_byte;
    logic        load_last;
    logic        load_ready;
    logic        load_done;
    logic [6:0]  load_count;
    logic        cpu_reset;
    logic [31:0] instr_address;
    logic [31:0] instr_readdata;
    logic        halted;
    logic        fetch_error;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] exp;
    } fvec_t;

    fvec_t tbl [7];

    mips_cpu_instr_memory #(.DEPTH(DEPTH), .BASE_ADDR(32'hBFC00000)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .load_valid     (load_valid),
        .load_byte      (load_byte),
        .load_last      (load_last),
        .load_ready     (load_ready),
        .load_done      (load_done),
        .load_count     (load_count),
        .cpu_reset      (cpu_reset),
        .instr_address  (instr_address),
        .instr_readdata (instr_readdata),
        .halted         (halted),
        .fetch_error    (fetch_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] bus(input logic [31:0] w);
`ifdef IMEM_BYTESWAP_EN
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
        return w;
`endif
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic apply_reset();
        load_valid = 1'b0;
        load_last  = 1'b0;
        reset_n    = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic send(input logic [7:0] b, input logic last);
        load_byte  = b;
        load_last  = last;
        load_valid = 1'b1;
        @(posedge clk);
        #1;
        load_valid = 1'b0;
        load_last  = 1'b0;
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] prog [8];
        prog = '{8'h24, 8'h21, 8'h00, 8'h04, 8'h18, 8'h20, 8'h00, 8'h04};
        tbl[0] = '{32'hBFC00000, bus(32'h24210004)};
        tbl[1] = '{32'hBFC00004, bus(32'h18200004)};
        tbl[2] = '{32'hBFC00008, 32'h0};
        tbl[3] = '{32'hBFC00002, 32'h0};
        tbl[4] = '{32'hBFBFFFFC, 32'h0};
        tbl[5] = '{32'hBFC00100, 32'h0};
        tbl[6] = '{32'h00000000, 32'h0};

        load_byte     = 8'h0;
        instr_address = 32'hBFC00000;
        apply_reset();

        check("rst_load_ready", 32'(load_ready), 32'd1);
        check("rst_load_done", 32'(load_done), 32'd0);
        check("rst_load_count", 32'(load_count), 32'd0);
        check("rst_cpu_reset", 32'(cpu_reset), 32'd1);
        check("rst_halted", 32'(halted), 32'd0);
        check("rst_fetch_error", 32'(fetch_error), 32'd0);
        check("rst_readdata", instr_readdata, 32'h0);

        // 8-byte program with an idle cycle between bytes
        for (int i = 0; i < 8; i++) begin
            if (i == 7) begin
                check("a_done_before", 32'(load_done), 32'd0);
                check("a_cpurst_before", 32'(cpu_reset), 32'd1);
            end
            send(prog[i], (i == 7));
            if (i == 3) begin
                check("a_count_w0", 32'(load_count), 32'd1);
                check("a_load_readdata", instr_readdata, 32'h0);
            end
            if (i < 7) idle();
        end
        check("a_count", 32'(load_count), 32'd2);
        check("a_done_after", 32'(load_done), 32'd1);
        check("a_cpurst_after", 32'(cpu_reset), 32'd0);
        check("a_ready_after", 32'(load_ready), 32'd0);

        for (int i = 0; i < 7; i++) begin
            instr_address = tbl[i].addr;
            #1;
            check($sformatf("fetch_%0d", i), instr_readdata, tbl[i].exp);
        end

        // Partial final word is zero-padded
        instr_address = 32'hBFC00000;
        apply_reset();
        send(8'h11, 1'b0); send(8'h22, 1'b0); send(8'h33, 1'b0); send(8'h44, 1'b0);
        send(8'hAA, 1'b0); send(8'hBB, 1'b1);
        check("b_count", 32'(load_count), 32'd2);
        check("b_word0", instr_readdata, bus(32'h11223344));
        instr_address = 32'hBFC00004;
        #1;
        check("b_word1_pad", instr_readdata, bus(32'hAABB0000));
        instr_address = 32'hBFC00008;
        #1;
        check("b_unloaded_rd", instr_readdata, 32'h0);
        check("b_ferr_before", 32'(fetch_error), 32'd0);
        idle();
        check("b_ferr_after", 32'(fetch_error), 32'd1);
        check("b_halted", 32'(halted), 32'd0);

        // Halt on address 0, then misaligned fetch error
        instr_address = 32'hBFC00000;
        apply_reset();
        send(8'h01, 1'b0); send(8'h02, 1'b0); send(8'h03, 1'b0); send(8'h04, 1'b1);
        check("c_count", 32'(load_count), 32'd1);
        instr_address = 32'h0;
        #1;
        check("c_halt_before", 32'(halted), 32'd0);
        idle();
        check("c_halt_after", 32'(halted), 32'd1);
        check("c_ferr_on_halt", 32'(fetch_error), 32'd0);
        instr_address = 32'hBFC00002;
        #1;
        check("c_misalign_rd", instr_readdata, 32'h0);
        idle();
        check("c_misalign_ferr", 32'(fetch_error), 32'd1);

        // Reset mid-load discards the partial word and prior valid bits
        instr_address = 32'hBFC00000;
        apply_reset();
        send(8'h55, 1'b0); send(8'h66, 1'b0); send(8'h77, 1'b0);
        apply_reset();
        check("d_rst_halted", 32'(halted), 32'd0);
        check("d_rst_ferr", 32'(fetch_error), 32'd0);
        send(8'hDE, 1'b0); send(8'hAD, 1'b0); send(8'hBE, 1'b0); send(8'hEF, 1'b1);
        check("d_count", 32'(load_count), 32'd1);
        check("d_word0", instr_readdata, bus(32'hDEADBEEF));
        idle();
        check("d_halted", 32'(halted), 32'd0);
        check("d_ferr", 32'(fetch_error), 32'd0);
        instr_address = 32'hBFC00004;
        #1;
        check("d_stale_word1", instr_readdata, 32'h0);
        instr_address = 32'hBFC00000;

        // Fill to DEPTH without load_last; trailing bytes must be refused
        apply_reset();
        for (int i = 0; i < 4 * DEPTH + 4; i++) begin
            if (i == 4 * DEPTH - 1) begin
                check("e_ready_last", 32'(load_ready), 32'd1);
            end
            if (i == 4 * DEPTH) begin
                check("e_count_full", 32'(load_count), 32'(DEPTH));
                check("e_ready_full", 32'(load_ready), 32'd0);
                check("e_done_full", 32'(load_done), 32'd1);
            end
            send((i < 4 * DEPTH) ? 8'(i) : 8'hEE, 1'b0);
        end
        check("e_count_after", 32'(load_count), 32'(DEPTH));
        check("e_word0", instr_readdata, bus(32'h00010203));
        instr_address = 32'hBFC000FC;
        #1;
        check("e_word_last", instr_readdata, bus(32'hFCFDFEFF));
        instr_address = 32'hBFC00100;
        #1;
        check("e_past_end", instr_readdata, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mips_cpu_instr_memory.md
# mips_cpu_instr_memory

Loadable instruction memory that sits on the instruction side of `mips_cpu_harvard` and answers its fetches. At power-up it accepts a big-endian program image as a byte stream and packs it into words. It then releases the CPU's reset and serves combinational fetches from the reset vector region. It also flags the CPU's halt (a fetch of address 0) and illegal fetches.

## Interface
Parameters:
- `DEPTH`, 64: number of 32-bit words; power of two.
- `BASE_ADDR`, 32'hBFC00000: byte address of word 0; word-aligned.

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `load_valid`  in  1  load byte present.
- `load_byte`  in  8  program byte; most significant byte of each word first.
- `load_last`  in  1  qualifies the final byte of the image.
- `load_ready`  out  1  block accepts load bytes.
- `load_done`  out  1  image committed; memory in run mode.
- `load_count`  out  $clog2(DEPTH)+1  words written.
- `cpu_reset`  out  1  active-high reset to the CPU.
- `instr_address`  in  32  CPU fetch byte address.
- `instr_readdata`  out  32  fetched word in CPU bus byte order.
- `halted`  out  1  sticky: CPU fetched address 0.
- `fetch_error`  out  1  sticky: illegal fetch in run mode.

## Operation
- States are LOAD and RUN. Reset enters LOAD.
- Per-word valid bits are cleared on reset. Array contents are not reset.
- **LOAD:**
  - `load_ready`=1.
  - A byte is accepted when `load_valid && load_ready` at a rising edge.
  - A 2-bit byte index selects the lane: bits 31:24, then 23:16, then 15:8, then 7:0.
  - The 4th accepted byte writes the assembled word at `wr_ptr`, sets its valid bit and increments `wr_ptr`/`load_count`.
- **End of image:**
  - When the accepted byte has `load_last`=1, the word is committed immediately. Unfilled lower lanes are zero-padded.
  - The state then moves to RUN.
  - `load_last` on a 4th byte commits normally; there is no extra word.
- **Full:**
  - When the commit makes `load_count`==DEPTH, the state moves to RUN whether or not `load_last` is set.
  - Bytes offered after that are not accepted.
- **RUN:**
  - `load_ready`=0, `load_done`=1, `cpu_reset`=0.
  - `load_*` inputs are ignored.
- **Fetch decode** (combinational):
  - A fetch hits when `instr_address[1:0]`==0, `BASE_ADDR <= instr_address < BASE_ADDR+4*DEPTH`, and the indexed word is valid.
  - A hit returns the word. Any miss returns 32'h0 (MIPS nop).
  - In LOAD, `instr_readdata`=0.
- **Flags**, sampled at each rising edge in RUN only:
  - `instr_address`==0 sets `halted`.
  - Any other miss sets `fetch_error`.
  - Both flags clear only on reset.

## Timing
- Reset values:
  - `load_ready`=1, `load_done`=0, `load_count`=0, `cpu_reset`=1.
  - `halted`=0, `fetch_error`=0, `instr_readdata`=0.
- One byte is accepted per cycle at full rate. The word write commits on the edge that accepts its last byte. Fetches see the word from the next cycle.
- `load_done` rises and `cpu_reset` falls one cycle after the terminal byte is accepted. All three of `load_ready`, `load_done` and `cpu_reset` are decoded from the state register.
- Fetch path: 0-cycle combinational from `instr_address` to `instr_readdata`.
- Flags are registered and assert one cycle after the offending address is presented at an edge.
- Reset asserted mid-load discards the partial word, clears `wr_ptr` and the valid bits, and returns to LOAD.

## Configuration
- `IMEM_BYTESWAP_EN`:
  - Defined: `instr_readdata` = {w[7:0], w[15:8], w[23:16], w[31:24]}. This is the little-endian bus order the CPU expects.
  - Undefined: `instr_readdata` = w, unchanged big-endian.
  - The zero miss value is unaffected either way.

## Structure
- Package `mips_imem_pkg`:
  - state enum {LOAD, RUN};
  - `IMEM_RESET_VECTOR` = 32'hBFC00000;
  - `HALT_ADDR` = 32'h0;
  - function `bswap32`.
- Sub-module `mips_imem_byte_packer`:
  - contains the byte index, lane shift register and zero-pad on last;
  - emits `word_valid`/`word`.
- The top level holds the array, the valid bits, `wr_ptr`, the FSM, the fetch decode and the flags.

## Test plan
- Load the 8 bytes 24 21 00 04 18 20 00 04 with `load_last` on the 8th byte.
  - `load_count`=2; `load_done`/`cpu_reset` transition 1 cycle later.
  - A fetch of 32'hBFC00004 returns 32'h04002018 with the macro defined and 32'h18200004 without it.
- Load 6 bytes with `load_last` on the 6th.
  - Word 1 = 32'hAABB0000 (padded); `load_count`=2.
  - A fetch of 32'hBFC00008 returns 0 and sets `fetch_error`.
- Stream 4*DEPTH+4 bytes without `load_last`.
  - RUN is entered after byte 4*DEPTH; `load_count`=DEPTH; `load_ready`=0.
  - The extra 4 bytes are not accepted.
- In RUN, drive `instr_address`=0.
  - `halted`=1 after the next edge; `fetch_error` stays 0.
  - Also drive 32'hBFC00002 → `fetch_error`=1 and readdata 0.
- Deassert `load_valid` on alternate cycles during load.
  - Packing is unaffected by the gaps.
- Assert reset after 3 bytes, then reload 4 bytes with `load_last`.
  - `load_count`=1 and word 0 = the new bytes.
  - `fetch_error`/`halted` remain cleared.
